// File: rtl/cla_nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder/subtractor that reuses a single 4-bit carry-lookahead
// slice, one nibble per cycle LSB first, with valid/ready handshakes on both sides.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;

  // Returns {carry_out, sum_nibble}; full lookahead, no adder operator.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g, p;
    logic       c1, c2, c3, co;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    co = g[3] | (p[3] & c3);
    return {co, p ^ {c3, c2, c1, c0}};
  endfunction

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  assign slice = cla4(a_nib, b_nib, carry_q);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) sum_d[4*i +: 4] = slice[3:0];
        end
        carry_d = slice[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d  = slice[4];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder at WIDTH=4, 16 and 32; sel picks the
// instance under test, the other two see in_valid/out_ready held low.
module tb_cla_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] a, b;
  int          sel;

  logic        ir4, ov4, co4, ir16, ov16, co16, ir32, ov32, co32;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;
  logic        obs_ir, obs_ov, obs_co;
  logic [31:0] obs_sum;

  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir4),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub), .out_valid(ov4),
    .out_ready(out_ready && sel == 0), .sum(s4), .cout(co4));
  cla_nibble_serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov16),
    .out_ready(out_ready && sel == 1), .sum(s16), .cout(co16));
  cla_nibble_serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir32),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov32),
    .out_ready(out_ready && sel == 2), .sum(s32), .cout(co32));

  always_comb begin
    case (sel)
      0:       begin obs_ir = ir4;  obs_ov = ov4;  obs_co = co4;  obs_sum = {28'b0, s4};  end
      1:       begin obs_ir = ir16; obs_ov = ov16; obs_co = co16; obs_sum = {16'b0, s16}; end
      default: begin obs_ir = ir32; obs_ov = ov32; obs_co = co32; obs_sum = s32;          end
    endcase
  end

  // Reference: {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), truncated to w bits.
  function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [32:0] m, e;
    m = (33'd1 << w) - 33'd1;
    e = ({1'b0, x} & m) + ({1'b0, s ? ~y : y} & m) + {32'b0, s ? 1'b1 : c};
    return {e[w], e[31:0] & m[31:0]};
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input logic ts);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!obs_ov && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!obs_ov) lat = -1;
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if (obs_ir !== 1'b1 || obs_ov !== 1'b0 || obs_sum !== 32'h0 || obs_co !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: got ir=%b ov=%b sum=%h cout=%b want ir=1 ov=0 sum=0 cout=0",
                 s, obs_ir, obs_ov, obs_sum, obs_co);
      end
    end
    sel = 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'h5555});
    issue(32'h1234, 32'h4321, 1'b0, 1'b0);
    wait_result(lat);
    e = exp_q.pop_front();
    total++;
    if (lat != 4) begin bad++; $display("FAIL basic latency: got %0d want 4", lat); end
    total++;
    if ({obs_co, obs_sum} !== e) begin
      bad++; $display("FAIL basic result: got %h want %h", {obs_co, obs_sum}, e);
    end
    handoff();
  endtask

  task automatic test_carry();
    logic [31:0] ta[2] = '{32'hFFFF, 32'hFFFF};
    logic [31:0] tb[2] = '{32'h0001, 32'h0000};
    logic        tc[2] = '{1'b0, 1'b1};
    int lat;
    logic [32:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 32'h0000});
      issue(ta[i], tb[i], tc[i], 1'b0);
      wait_result(lat);
      e = exp_q.pop_front();
      total++;
      if (lat != 4) begin bad++; $display("FAIL carry[%0d] latency: got %0d want 4", i, lat); end
      total++;
      if ({obs_co, obs_sum} !== e) begin
        bad++; $display("FAIL carry[%0d] result: got %h want %h", i, {obs_co, obs_sum}, e);
      end
      handoff();
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta[2] = '{32'h0005, 32'h0007};
    logic [31:0] tb[2] = '{32'h0007, 32'h0005};
    logic [32:0] ex[2] = '{{1'b0, 32'hFFFE}, {1'b1, 32'h0002}};
    int lat;
    logic [32:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ex[i]);
      issue(ta[i], tb[i], 1'b1, 1'b1);
      wait_result(lat);
      e = exp_q.pop_front();
      total++;
      if (lat != 4) begin bad++; $display("FAIL sub[%0d] latency: got %0d want 4", i, lat); end
      total++;
      if ({obs_co, obs_sum} !== e) begin
        bad++; $display("FAIL sub[%0d] result: got %h want %h", i, {obs_co, obs_sum}, e);
      end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'h2345});
    issue(32'h1234, 32'h1111, 1'b0, 1'b0);
    wait_result(lat);
    e = exp_q.pop_front();
    total++;
    if ({obs_co, obs_sum} !== e || lat != 4) begin
      bad++; $display("FAIL bp first: got %h lat %0d want %h lat 4", {obs_co, obs_sum}, lat, e);
    end
    @(negedge clk);
    a = 32'hAAAA; b = 32'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (obs_ov !== 1'b1 || obs_ir !== 1'b0 || {obs_co, obs_sum} !== e) begin
        bad++;
        $display("FAIL bp hold[%0d]: got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                 i, obs_ov, obs_ir, {obs_co, obs_sum}, e);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin
      bad++; $display("FAIL bp handoff: got ov=%b ir=%b want ov=0 ir=1", obs_ov, obs_ir);
    end
    exp_q.push_back({1'b0, 32'hBBBC});
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (obs_ir !== 1'b0) begin bad++; $display("FAIL bp accept: got ir=%b want 0", obs_ir); end
    wait_result(lat);
    e = exp_q.pop_front();
    total++;
    if ({obs_co, obs_sum} !== e || lat != 4) begin
      bad++; $display("FAIL bp second: got %h lat %0d want %h lat 4", {obs_co, obs_sum}, lat, e);
    end
    handoff();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [32:0] e;
    issue(32'h1111, 32'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs_ir !== 1'b1 || obs_ov !== 1'b0 || obs_sum !== 32'h0 || obs_co !== 1'b0) begin
      bad++;
      $display("FAIL midrun reset: got ir=%b ov=%b sum=%h cout=%b want ir=1 ov=0 sum=0 cout=0",
               obs_ir, obs_ov, obs_sum, obs_co);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({1'b0, 32'h0100});
    issue(32'h00FF, 32'h0001, 1'b0, 1'b0);
    wait_result(lat);
    e = exp_q.pop_front();
    total++;
    if ({obs_co, obs_sum} !== e || lat != 4) begin
      bad++; $display("FAIL after reset: got %h lat %0d want %h lat 4", {obs_co, obs_sum}, lat, e);
    end
    handoff();
  endtask

  task automatic test_random(input int s, input int n);
    int w, nib, issued, done, budget, k;
    logic [31:0] m;
    logic [32:0] e;
    logic prev_ov, acc;
    sel = s;
    w = (s == 0) ? 4 : (s == 1) ? 16 : 32;
    nib = w / 4;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    issued = 0; done = 0; budget = 0; cyc = 0; prev_ov = 1'b0;
    exp_q.delete();
    acc_q.delete();
    while ((issued < n || done < n) && budget < 40 * n) begin
      @(negedge clk);
      if (obs_ov && !prev_ov) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rand w%0d spurious out_valid: got res=%h want none", w, {obs_co, obs_sum});
        end else begin
          e = exp_q.pop_front();
          k = acc_q.pop_front();
          total++;
          if ({obs_co, obs_sum} !== e) begin
            bad++; $display("FAIL rand w%0d result #%0d: got %h want %h", w, done, {obs_co, obs_sum}, e);
          end
          total++;
          if (cyc - k != nib) begin
            bad++; $display("FAIL rand w%0d latency #%0d: got %0d want %0d", w, done, cyc - k, nib);
          end
          done++;
        end
      end
      prev_ov = obs_ov;
      in_valid = (issued < n) && ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? m : ($urandom & m);
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & m);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1 acc = in_valid && obs_ir;
      @(posedge clk);
      cyc++;
      budget++;
      if (acc) begin
        exp_q.push_back(model(w, a, b, cin, sub));
        acc_q.push_back(cyc);
        issued++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (done != n) begin bad++; $display("FAIL rand w%0d count: got %0d want %0d", w, done, n); end
    #1;
    if (obs_ov) handoff();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0; sel = 1;
    test_reset();
    test_basic();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random(1, 1000);
    test_random(0, 400);
    test_random(2, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
